// File: rtl/raxi_rc_pkg.sv
// raxi_rc_pkg: shared definitions for the RC completion frame buffer.
//   clog2      - ceiling log2 used to size the mod field from the keep width
//   *_OFS      - read-word field offsets for the default 512-bit build
//   wr_state_t - write-side frame state (IDLE / FRAME)
package raxi_rc_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Offsets for the default configuration (DATA_W = 512).
   // The top derives its own offsets from the actual DATA_W.
   localparam int unsigned DEF_DATA_W = 512;
   localparam int unsigned DEF_RW     = DEF_DATA_W + clog2(DEF_DATA_W / 8) + 2;
   localparam int unsigned EOP_OFS    = DEF_RW - 1;
   localparam int unsigned ERR_OFS    = DEF_RW - 2;
   localparam int unsigned MOD_OFS    = DEF_DATA_W;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } wr_state_t;

endpackage

// File: rtl/raxi_sdp_ram.sv
// raxi_sdp_ram: single-clock simple-dual-port RAM, registered read.
//   clk, rst       - clock; async active-high reset clears the read register
//   we/waddr/wdata - write port
//   re/raddr       - read port; rdata updates one cycle after re and holds
//   rdata          - read data
module raxi_sdp_ram #(
   parameter int unsigned W = 8,
   parameter int unsigned A = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [W-1:0] wdata,
   input  logic         re,
   input  logic [A-1:0] raddr,
   output logic [W-1:0] rdata
);

   logic [W-1:0] mem [2**A];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/raxi_rc_frm_buf.sv
// raxi_rc_frm_buf: store-and-forward receive buffer for the PCIe RC AXI-Stream.
// Only complete, error-free frames become readable; discontinued or overflowing
// frames are rolled back so they leave nothing behind.
//   pcie_clk/pcie_rst        - clock, async active-high reset
//   s_axis_rc_*              - completion stream in (tready is registered)
//   rc_rx_rd/rc_rx_rdata     - read strobe, word {eop, err, mod, data}, 1-cycle latency
//   rc_rx_ef                 - no committed word available
//   rc_wr_data_cnt           - words held, including the open frame
//   rc_rd_data_cnt           - committed words available
//   rc_frm_cnt/rc_drop_cnt   - committed / dropped frame counters (wrapping)
//   fifo_err                 - pulse on empty read or overflow
// Build option: RAXI_RC_BSWAP_EN reverses bytes within each 32-bit dword.
module raxi_rc_frm_buf
   import raxi_rc_pkg::*;
#(
   parameter  int unsigned DATA_W     = 512,
   parameter  int unsigned A_DTH      = 9,
   parameter  int unsigned FULL_LEVEL = 400,
   parameter  int unsigned DISC_POS   = 42,
   parameter  int unsigned USER_W     = 75,
   parameter  int unsigned CNT_W      = 16,
   localparam int unsigned KEEP_W     = DATA_W / 8,
   localparam int unsigned MOD_W      = clog2(KEEP_W),
   localparam int unsigned RW         = DATA_W + MOD_W + 2
) (
   input  logic              pcie_clk,
   input  logic              pcie_rst,
   input  logic [DATA_W-1:0] s_axis_rc_tdata,
   input  logic [USER_W-1:0] s_axis_rc_tuser,
   input  logic              s_axis_rc_tlast,
   input  logic [KEEP_W-1:0] s_axis_rc_tkeep,
   input  logic              s_axis_rc_tvalid,
   output logic              s_axis_rc_tready,
   input  logic              rc_rx_rd,
   output logic [RW-1:0]     rc_rx_rdata,
   output logic              rc_rx_ef,
   output logic [A_DTH:0]    rc_wr_data_cnt,
   output logic [A_DTH:0]    rc_rd_data_cnt,
   output logic [CNT_W-1:0]  rc_frm_cnt,
   output logic [CNT_W-1:0]  rc_drop_cnt,
   output logic              fifo_err
);

   localparam int unsigned     EOP_BIT = RW - 1;
   localparam int unsigned     ERR_BIT = RW - 2;
   localparam int unsigned     MOD_LSB = DATA_W;
   localparam logic [A_DTH:0]  DEPTH_W = (A_DTH+1)'(2**A_DTH);
   localparam logic [A_DTH:0]  FULL_W  = (A_DTH+1)'(FULL_LEVEL);

   logic              acc;
   logic [DATA_W-1:0] din;
   logic [MOD_W-1:0]  hi, mod_in;
   logic              unused_tuser;

   logic              s1_vld, s1_last, s1_disc;
   logic [DATA_W-1:0] s1_data;
   logic [MOD_W-1:0]  s1_mod;

   wr_state_t         state;
   logic [A_DTH:0]    wptr, cptr, rptr, used;
   logic              ovf, ovf_eff, full, ovf_now, wr_en, rd_ok, in_pkt;
   logic [RW-1:0]     wr_word;

   always_comb acc = s_axis_rc_tvalid & s_axis_rc_tready;
   always_comb unused_tuser = ^s_axis_rc_tuser;

`ifdef RAXI_RC_BSWAP_EN
   always_comb begin
      din = '0;
      for (int unsigned d = 0; d < DATA_W / 32; d++)
         for (int unsigned b = 0; b < 4; b++)
            din[d*32 + b*8 +: 8] = s_axis_rc_tdata[d*32 + (3-b)*8 +: 8];
   end
`else
   always_comb din = s_axis_rc_tdata;
`endif

   // Highest set keep bit; all-zero keep leaves hi=0, giving mod=KEEP_W-1.
   always_comb begin
      hi = '0;
      for (int unsigned i = 0; i < KEEP_W; i++)
         if (s_axis_rc_tkeep[i]) hi = MOD_W'(i);
      mod_in = MOD_W'(KEEP_W - 1) - hi;
   end

   always_ff @(posedge pcie_clk or posedge pcie_rst) begin
      if (pcie_rst) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_disc <= 1'b0;
         s1_data <= '0;
         s1_mod  <= '0;
      end else begin
         s1_vld <= acc;
         if (acc) begin
            s1_data <= din;
            s1_last <= s_axis_rc_tlast;
            s1_disc <= s_axis_rc_tuser[DISC_POS];
            s1_mod  <= s_axis_rc_tlast ? mod_in : '0;
         end
      end
   end

   always_comb begin
      used    = wptr - rptr;
      full    = (used == DEPTH_W);
      ovf_eff = ovf & (state == FRAME);
      ovf_now = s1_vld & full & ~ovf_eff;
      wr_en   = s1_vld & ~full & ~ovf_eff;
      rd_ok   = rc_rx_rd & ~rc_rx_ef;
      rc_rx_ef       = (cptr == rptr);
      rc_wr_data_cnt = used;
      rc_rd_data_cnt = cptr - rptr;
      wr_word = '0;
      wr_word[EOP_BIT]           = s1_last;
      wr_word[ERR_BIT]           = s1_last & s1_disc;
      wr_word[MOD_LSB +: MOD_W]  = s1_mod;
      wr_word[DATA_W-1:0]        = s1_data;
   end

   always_ff @(posedge pcie_clk or posedge pcie_rst) begin
      if (pcie_rst) begin
         state            <= IDLE;
         wptr             <= '0;
         cptr             <= '0;
         rptr             <= '0;
         ovf              <= 1'b0;
         in_pkt           <= 1'b0;
         s_axis_rc_tready <= 1'b0;
         rc_frm_cnt       <= '0;
         rc_drop_cnt      <= '0;
         fifo_err         <= 1'b0;
      end else begin
         fifo_err <= (rc_rx_rd & rc_rx_ef) | ovf_now;
         if (rd_ok) rptr <= rptr + 1'b1;
         if (acc) in_pkt <= ~s_axis_rc_tlast;

         // Withdraw ready only at a frame boundary so a frame is never split.
         if (!s_axis_rc_tready) begin
            if (used < FULL_W) s_axis_rc_tready <= 1'b1;
         end else if (used >= FULL_W &&
                      ((acc && s_axis_rc_tlast) || (!s_axis_rc_tvalid && !in_pkt))) begin
            s_axis_rc_tready <= 1'b0;
         end

         if (s1_vld) begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (s1_last) begin
               state <= IDLE;
               ovf   <= 1'b0;
               // Rollback overrides the increment above.
               if (s1_disc | ovf_eff | full) begin
                  wptr        <= cptr;
                  rc_drop_cnt <= rc_drop_cnt + 1'b1;
               end else begin
                  cptr       <= wptr + 1'b1;
                  rc_frm_cnt <= rc_frm_cnt + 1'b1;
               end
            end else begin
               state <= FRAME;
               ovf   <= ovf_eff | full;
            end
         end
      end
   end

   raxi_sdp_ram #(
      .W (RW),
      .A (A_DTH)
   ) u_ram (
      .clk   (pcie_clk),
      .rst   (pcie_rst),
      .we    (wr_en),
      .waddr (wptr[A_DTH-1:0]),
      .wdata (wr_word),
      .re    (rd_ok),
      .raddr (rptr[A_DTH-1:0]),
      .rdata (rc_rx_rdata)
   );

endmodule

// File: tb/tb_raxi_rc_frm_buf.sv
// tb_raxi_rc_frm_buf: directed bench for raxi_rc_frm_buf.
// Instance a: default 512-bit build. Instance b: 256-bit, 16-word buffer.
module tb_raxi_rc_frm_buf;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int b_pulses = 0;

   logic [511:0] a_tdata;  logic [74:0] a_tuser;  logic a_tlast;  logic [63:0] a_tkeep;
   logic a_tvalid, a_tready, a_rd, a_ef, a_ferr;
   logic [519:0] a_rdata;  logic [9:0] a_wcnt, a_rcnt;  logic [15:0] a_frm, a_drop;

   logic [255:0] b_tdata;  logic [74:0] b_tuser;  logic b_tlast;  logic [31:0] b_tkeep;
   logic b_tvalid, b_tready, b_rd, b_ef, b_ferr;
   logic [262:0] b_rdata;  logic [4:0] b_wcnt, b_rcnt;  logic [15:0] b_frm, b_drop;

   raxi_rc_frm_buf u_a (
      .pcie_clk(clk), .pcie_rst(rst),
      .s_axis_rc_tdata(a_tdata), .s_axis_rc_tuser(a_tuser), .s_axis_rc_tlast(a_tlast),
      .s_axis_rc_tkeep(a_tkeep), .s_axis_rc_tvalid(a_tvalid), .s_axis_rc_tready(a_tready),
      .rc_rx_rd(a_rd), .rc_rx_rdata(a_rdata), .rc_rx_ef(a_ef),
      .rc_wr_data_cnt(a_wcnt), .rc_rd_data_cnt(a_rcnt),
      .rc_frm_cnt(a_frm), .rc_drop_cnt(a_drop), .fifo_err(a_ferr)
   );

   raxi_rc_frm_buf #(.DATA_W(256), .A_DTH(4), .FULL_LEVEL(15)) u_b (
      .pcie_clk(clk), .pcie_rst(rst),
      .s_axis_rc_tdata(b_tdata), .s_axis_rc_tuser(b_tuser), .s_axis_rc_tlast(b_tlast),
      .s_axis_rc_tkeep(b_tkeep), .s_axis_rc_tvalid(b_tvalid), .s_axis_rc_tready(b_tready),
      .rc_rx_rd(b_rd), .rc_rx_rdata(b_rdata), .rc_rx_ef(b_ef),
      .rc_wr_data_cnt(b_wcnt), .rc_rd_data_cnt(b_rcnt),
      .rc_frm_cnt(b_frm), .rc_drop_cnt(b_drop), .fifo_err(b_ferr)
   );

   always @(negedge clk) if (b_ferr === 1'b1) b_pulses++;

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] pa(input int k);
      return {16{32'hA5A5_0000 + 32'(k)}};
   endfunction

   function automatic logic [255:0] pb(input int k);
      return {8{32'hB0B0_0000 + 32'(k)}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_send(input logic [511:0] d, input logic [63:0] k, input logic l, input logic dsc);
      int w;
      a_tdata = d; a_tkeep = k; a_tlast = l; a_tuser = '0; a_tuser[42] = dsc; a_tvalid = 1'b1;
      w = 0;
      while (a_tready !== 1'b1 && w < 50) begin step(); w++; end
      if (w >= 50) begin
         checks++; errors++;
         $display("FAIL a_send_timeout tready=%0b required=1", a_tready);
      end else step();
   endtask

   task automatic b_send(input logic [255:0] d, input logic [31:0] k, input logic l);
      int w;
      b_tdata = d; b_tkeep = k; b_tlast = l; b_tuser = '0; b_tvalid = 1'b1;
      w = 0;
      while (b_tready !== 1'b1 && w < 50) begin step(); w++; end
      if (w >= 50) begin
         checks++; errors++;
         $display("FAIL b_send_timeout tready=%0b required=1", b_tready);
      end else step();
   endtask

   task automatic a_read(output logic [519:0] q);
      a_rd = 1'b1; step(); a_rd = 1'b0; q = a_rdata;
   endtask

   task automatic b_read(output logic [262:0] q);
      b_rd = 1'b1; step(); b_rd = 1'b0; q = b_rdata;
   endtask

   task automatic check_a_reset_values(input string tag);
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL %s_tready got=%0b exp=0", tag, a_tready); end
      checks++; if (a_ef !== 1'b1) begin errors++; $display("FAIL %s_ef got=%0b exp=1", tag, a_ef); end
      checks++; if (a_rdata !== '0) begin errors++; $display("FAIL %s_rdata got=%h exp=0", tag, a_rdata); end
      checks++; if (a_wcnt !== 10'd0 || a_rcnt !== 10'd0) begin errors++; $display("FAIL %s_cnt got=%0d/%0d exp=0/0", tag, a_wcnt, a_rcnt); end
      checks++; if (a_frm !== 16'd0 || a_drop !== 16'd0) begin errors++; $display("FAIL %s_stat got=%0d/%0d exp=0/0", tag, a_frm, a_drop); end
      checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL %s_ferr got=%0b exp=0", tag, a_ferr); end
   endtask

   task automatic test_reset();
      repeat (3) step();
      check_a_reset_values("rst");
      checks++; if (b_tready !== 1'b0 || b_ef !== 1'b1) begin errors++; $display("FAIL rst_b got=%0b/%0b exp=0/1", b_tready, b_ef); end
      rst = 1'b0;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL rst_release_tready got=%0b exp=0", a_tready); end
      step();
      checks++; if (a_tready !== 1'b1 || b_tready !== 1'b1) begin errors++; $display("FAIL rst_first_clk_tready got=%0b/%0b exp=1/1", a_tready, b_tready); end
   endtask

   task automatic test_three_beat();
      logic [519:0] q;
      a_send(pa(0), '1, 1'b0, 1'b0);
      a_send(pa(1), '1, 1'b0, 1'b0);
      a_send(pa(2), 64'h0000_0000_ffff_ffff, 1'b1, 1'b0);
      a_tvalid = 1'b0;
      checks++; if (a_ef !== 1'b1) begin errors++; $display("FAIL tb_ef_before_commit got=%0b exp=1", a_ef); end
      step();
      checks++; if (a_ef !== 1'b0) begin errors++; $display("FAIL tb_ef_after_commit got=%0b exp=0", a_ef); end
      checks++; if (a_rcnt !== 10'd3) begin errors++; $display("FAIL tb_rcnt got=%0d exp=3", a_rcnt); end
      checks++; if (a_frm !== 16'd1) begin errors++; $display("FAIL tb_frm got=%0d exp=1", a_frm); end
      a_read(q);
      checks++; if (q !== {1'b0, 1'b0, 6'd0, pa(0)}) begin errors++; $display("FAIL tb_word0 got=%h exp=%h", q, {1'b0, 1'b0, 6'd0, pa(0)}); end
      a_read(q);
      checks++; if (q !== {1'b0, 1'b0, 6'd0, pa(1)}) begin errors++; $display("FAIL tb_word1 got=%h exp=%h", q, {1'b0, 1'b0, 6'd0, pa(1)}); end
      a_read(q);
      checks++; if (q !== {1'b1, 1'b0, 6'd32, pa(2)}) begin errors++; $display("FAIL tb_word2 got=%h exp=%h", q, {1'b1, 1'b0, 6'd32, pa(2)}); end
      checks++; if (a_ef !== 1'b1) begin errors++; $display("FAIL tb_ef_drained got=%0b exp=1", a_ef); end
   endtask

   task automatic test_discontinue(output logic [519:0] last_q);
      logic [519:0] q;
      a_send(pa(10), '1, 1'b0, 1'b0);
      a_send(pa(11), '1, 1'b1, 1'b1);
      a_tvalid = 1'b0;
      checks++; if (a_wcnt !== 10'd1) begin errors++; $display("FAIL disc_wcnt_open got=%0d exp=1", a_wcnt); end
      step();
      checks++; if (a_wcnt !== 10'd0) begin errors++; $display("FAIL disc_wcnt_rollback got=%0d exp=0", a_wcnt); end
      checks++; if (a_ef !== 1'b1) begin errors++; $display("FAIL disc_ef got=%0b exp=1", a_ef); end
      checks++; if (a_drop !== 16'd1) begin errors++; $display("FAIL disc_drop got=%0d exp=1", a_drop); end
      a_send(pa(12), 64'h0, 1'b1, 1'b0);
      a_tvalid = 1'b0;
      step();
      checks++; if (a_rcnt !== 10'd1 || a_ef !== 1'b0) begin errors++; $display("FAIL disc_good_rcnt got=%0d/%0b exp=1/0", a_rcnt, a_ef); end
      a_read(q);
      checks++; if (q !== {1'b1, 1'b0, 6'd63, pa(12)}) begin errors++; $display("FAIL disc_good_word got=%h exp=%h", q, {1'b1, 1'b0, 6'd63, pa(12)}); end
      checks++; if (a_frm !== 16'd2) begin errors++; $display("FAIL disc_frm got=%0d exp=2", a_frm); end
      last_q = q;
   endtask

   task automatic test_empty_read(input logic [519:0] last_q);
      checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL er_ferr_idle got=%0b exp=0", a_ferr); end
      a_rd = 1'b1; step(); a_rd = 1'b0;
      checks++; if (a_ferr !== 1'b1) begin errors++; $display("FAIL er_ferr_pulse got=%0b exp=1", a_ferr); end
      checks++; if (a_rdata !== last_q) begin errors++; $display("FAIL er_rdata_hold got=%h exp=%h", a_rdata, last_q); end
      step();
      checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL er_ferr_end got=%0b exp=0", a_ferr); end
      checks++; if (a_ef !== 1'b1 || a_rcnt !== 10'd0) begin errors++; $display("FAIL er_rptr got=%0b/%0d exp=1/0", a_ef, a_rcnt); end
   endtask

   task automatic test_full_level();
      logic [519:0] q;
      int n;
      n = 0;
      a_tkeep = '1; a_tlast = 1'b1; a_tuser = '0; a_tvalid = 1'b1;
      while (n < 600) begin
         if (a_tready !== 1'b1) break;
         a_tdata = {16{32'(n)}};
         step();
         n++;
      end
      a_tvalid = 1'b0;
      checks++; if (n !== 402) begin errors++; $display("FAIL full_accepted got=%0d exp=402", n); end
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL full_tready got=%0b exp=0", a_tready); end
      step(); step();
      checks++; if (a_wcnt !== 10'd402 || a_rcnt !== 10'd402) begin errors++; $display("FAIL full_cnt got=%0d/%0d exp=402/402", a_wcnt, a_rcnt); end
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL full_tready_hold got=%0b exp=0", a_tready); end
      for (int i = 0; i < 10; i++) begin
         a_read(q);
         checks++; if (q !== {1'b1, 1'b0, 6'd0, {16{32'(i)}}}) begin errors++; $display("FAIL full_read%0d got=%h exp=%h", i, q, {1'b1, 1'b0, 6'd0, {16{32'(i)}}}); end
      end
      step();
      checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL full_tready_back got=%0b exp=1", a_tready); end
      checks++; if (a_frm !== 16'd404) begin errors++; $display("FAIL full_frm got=%0d exp=404", a_frm); end
   endtask

   task automatic test_overflow();
      logic [262:0] q;
      int p0;
      b_send(pb(1), '1, 1'b0);
      b_send(pb(2), 32'h0000_00ff, 1'b1);
      b_tvalid = 1'b0;
      step();
      checks++; if (b_rcnt !== 5'd2) begin errors++; $display("FAIL ovf_pre_rcnt got=%0d exp=2", b_rcnt); end
      p0 = b_pulses;
      for (int i = 0; i < 18; i++) b_send(pb(100 + i), '1, (i == 17));
      b_tvalid = 1'b0;
      step(); step();
      checks++; if (b_pulses - p0 !== 1) begin errors++; $display("FAIL ovf_ferr_pulses got=%0d exp=1", b_pulses - p0); end
      checks++; if (b_drop !== 16'd1 || b_frm !== 16'd1) begin errors++; $display("FAIL ovf_stat got=%0d/%0d exp=1/1", b_drop, b_frm); end
      checks++; if (b_wcnt !== 5'd2 || b_rcnt !== 5'd2) begin errors++; $display("FAIL ovf_cnt got=%0d/%0d exp=2/2", b_wcnt, b_rcnt); end
      b_read(q);
      checks++; if (q !== {1'b0, 1'b0, 5'd0, pb(1)}) begin errors++; $display("FAIL ovf_word0 got=%h exp=%h", q, {1'b0, 1'b0, 5'd0, pb(1)}); end
      b_read(q);
      checks++; if (q !== {1'b1, 1'b0, 5'd24, pb(2)}) begin errors++; $display("FAIL ovf_word1 got=%h exp=%h", q, {1'b1, 1'b0, 5'd24, pb(2)}); end
      step();
      checks++; if (b_ef !== 1'b1 || b_tready !== 1'b1) begin errors++; $display("FAIL ovf_after got=%0b/%0b exp=1/1", b_ef, b_tready); end
   endtask

   task automatic test_reset_mid_frame();
      logic [519:0] q;
      a_send(pa(20), '1, 1'b0, 1'b0);
      a_send(pa(21), '1, 1'b0, 1'b0);
      a_tvalid = 1'b0;
      rst = 1'b1;
      #1;
      check_a_reset_values("mrst");
      step();
      rst = 1'b0;
      checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL mrst_release_tready got=%0b exp=0", a_tready); end
      step();
      checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL mrst_tready got=%0b exp=1", a_tready); end
      a_send(pa(30), '1, 1'b1, 1'b0);
      a_tvalid = 1'b0;
      step();
      checks++; if (a_rcnt !== 10'd1 || a_frm !== 16'd1) begin errors++; $display("FAIL mrst_rcnt got=%0d/%0d exp=1/1", a_rcnt, a_frm); end
      a_read(q);
      checks++; if (q !== {1'b1, 1'b0, 6'd0, pa(30)}) begin errors++; $display("FAIL mrst_word got=%h exp=%h", q, {1'b1, 1'b0, 6'd0, pa(30)}); end
      checks++; if (a_ef !== 1'b1) begin errors++; $display("FAIL mrst_ef got=%0b exp=1", a_ef); end
   endtask

   initial begin
      logic [519:0] lq;
      rst = 1'b1;
      a_tdata = '0; a_tuser = '0; a_tlast = 1'b0; a_tkeep = '0; a_tvalid = 1'b0; a_rd = 1'b0;
      b_tdata = '0; b_tuser = '0; b_tlast = 1'b0; b_tkeep = '0; b_tvalid = 1'b0; b_rd = 1'b0;
      test_reset();
      test_three_beat();
      test_discontinue(lq);
      test_empty_read(lq);
      test_full_level();
      test_overflow();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/raxi_rc_frm_buf.md
Name: raxi_rc_frm_buf

Overview:
- Parametrised single-clock receive buffer for the PCIe RC (requester completion) AXI-Stream interface.
- Stores complete frames only (store-and-forward) and computes a per-beat mod (invalid trailing byte count) from tkeep.
- Drops whole frames that end with discontinue set or that overflow, by rolling the write pointer back. Drops leave no residue in the buffer.
- Sits between the PCIe core RC port and the user completion parser. Supports 256- and 512-bit cores.

Parameters:
- DATA_W, 512, data width in bits; legal values 256 and 512.
- A_DTH, 9, address width; DEPTH = 2^A_DTH words.
- FULL_LEVEL, 400, used-word threshold at which tready is withdrawn, at a frame boundary only.
- DISC_POS, 42, bit index of discontinue within tuser.
- USER_W, 75, tuser width.
- CNT_W, 16, statistics counter width.
- Derived, not overridable: KEEP_W = DATA_W/8; MOD_W = clog2(KEEP_W); RW = DATA_W+MOD_W+2.

Ports:
- pcie_clk  in  1  sole clock.
- pcie_rst  in  1  asynchronous reset, active-high.
- s_axis_rc_tdata  in  DATA_W  completion data.
- s_axis_rc_tuser  in  USER_W  sideband; only bit DISC_POS is used.
- s_axis_rc_tlast  in  1  last beat of frame.
- s_axis_rc_tkeep  in  KEEP_W  byte enables.
- s_axis_rc_tvalid  in  1  beat valid.
- s_axis_rc_tready  out  1  registered ready.
- rc_rx_rd  in  1  read strobe.
- rc_rx_rdata  out  RW  read word: {eop, err, mod[MOD_W-1:0], data}.
- rc_rx_ef  out  1  no committed word available.
- rc_wr_data_cnt  out  A_DTH+1  words written, including the uncommitted frame.
- rc_rd_data_cnt  out  A_DTH+1  committed words available for reading.
- rc_frm_cnt  out  CNT_W  frames committed, wrapping.
- rc_drop_cnt  out  CNT_W  frames dropped, wrapping.
- fifo_err  out  1  one-cycle pulse on underflow read or overflow drop.

Behaviour:
- Reset (async assert, sync release):
  - tready=0, ef=1, rdata=0, all counts=0, fifo_err=0.
  - wptr, commit pointer cptr and rptr all = 0; any partial frame is discarded.
  - tready rises on the first clock after release.
- Accept: a beat is accepted when tvalid&tready. Stage 1 registers data, keep, last and disc. The RAM write happens in the following cycle, so write latency = 2 cycles.
- mod:
  - 0 on non-last beats.
  - On the last beat, mod = KEEP_W-1-(index of highest set tkeep bit).
  - tkeep all-ones gives 0; tkeep all-zero gives KEEP_W-1.
- Word fields: err = last & disc; eop = last.
- Write states:
  - IDLE: no frame open. The first accepted beat moves to FRAME.
  - FRAME: each beat writes at wptr and increments it. On eop:
    - err=0 and no overflow: cptr<=wptr+1; rc_frm_cnt++.
    - err=1 or overflow flagged: wptr<=cptr; rc_drop_cnt++.
    - Either way return to IDLE.
  - Single-beat frame: IDLE→commit/rollback in the same write cycle.
- Overflow: a beat arriving when wptr-rptr == DEPTH is not written. The overflow flag is set and fifo_err pulses once. Later beats of the frame are discarded, and the frame is dropped at eop.
- tready:
  - Clears when used >= FULL_LEVEL and (tvalid==0, or an accepted beat has tlast). It never drops mid-frame.
  - Sets when used < FULL_LEVEL.
- Read:
  - rc_rx_ef = (cptr==rptr).
  - rc_rx_rd with ef=0 increments rptr; rdata is valid 1 cycle later and holds until the next read.
  - rc_rx_rd with ef=1 is ignored and pulses fifo_err.
- Simultaneous commit and read: ef and rd_data_cnt reflect the commit on the next cycle.
- Pointers are A_DTH+1 bits, so full and empty are distinguished by the MSB.
- Counters wrap from 2^CNT_W-1 to 0.

Optional Feature:
- RAXI_RC_BSWAP_EN defined: stage 1 reverses byte order within each 32-bit dword of tdata (big-endian DW view). tkeep and mod are unchanged.
- Undefined: tdata is stored unchanged.

Decomposition:
- Package raxi_rc_pkg holds:
  - clog2 function.
  - Field offset constants EOP_OFS=RW-1, ERR_OFS=RW-2, MOD_OFS=DATA_W.
  - Write state encoding IDLE/FRAME.
- One sub-module: raxi_sdp_ram, single-clock simple-dual-port RAM of width RW and depth 2^A_DTH, with registered read (1-cycle latency).

Test Plan:
- 3-beat frame, DATA_W=512, last tkeep=64'h0000_0000_ffff_ffff → ef falls 1 cycle after commit; reads give mods 0, 0, 32, with eop=1 only on word 3; rc_frm_cnt=1.
- 2-beat frame, tuser[42]=1 on last → ef stays 1; wptr back to 0; rc_drop_cnt=1; rc_wr_data_cnt returns to 0. A following good frame reads back intact.
- Stream 1-beat frames, no reads, FULL_LEVEL=400 → tready falls after the frame that reaches 400 used words, never mid-frame. Reading 10 words makes tready=1 again.
- Force rc_rx_rd while ef=1 → fifo_err pulses exactly 1 cycle; rptr unchanged.
- A_DTH=4, FULL_LEVEL=15, an 18-beat frame → overflow drops the frame; fifo_err pulses once; rc_drop_cnt=1; previously committed data is unaffected.
- Assert pcie_rst mid-frame (beat 2 of 4) → all outputs return to their reset values; tready=1 one cycle after release; the partial frame never appears.
